// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control logic:
// hazard controller state encoding, register index width, the bubble
// control word and the load-use detection helper.
package riscv_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SQUASH   = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    // Width of the ID/EX control bundle; a bubble clears every control bit.
    localparam int                CTRL_W      = 8;
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    // A load in execute whose destination feeds the decode instruction.
    // x0 is hard-wired to zero and never creates a dependency.
    function automatic logic load_use_hazard(
        input logic                 mem_read,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 uses_rs2
    );
        return mem_read && (rd != '0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating performance counter: counts cycles where inc is high and
// sticks at all-ones instead of wrapping.
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Count up on inc, holding at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, taken-branch
// redirect flushes with a fetch-latency squash tail, and data-memory wait
// freezes with a sticky timeout flag.
// Build option: define HAZARD_PERF_CNT_EN to implement stall_cnt/flush_cnt;
// without it both counters are tied to zero.
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int IMEM_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] IF_ID_rs1,
    input  logic [REG_IDX_W-1:0] IF_ID_rs2,
    input  logic                 IF_ID_uses_rs2,
    input  logic [REG_IDX_W-1:0] ID_EX_rd,
    input  logic                 ID_EX_MemRead,
    input  logic                 EX_MEM_BranchTaken,
    input  logic                 EX_MEM_MemAccess,
    input  logic                 dmem_ready,
    output logic                 PC_Write,
    output logic                 IF_ID_Write,
    output logic                 ID_EX_Write,
    output logic                 EX_MEM_Write,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 EX_MEM_Flush,
    output logic                 MEM_WB_Flush,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int SQ_W   = (IMEM_LAT < 2) ? 1 : $clog2(IMEM_LAT + 1);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hazard_state_t     state_reg, state_next;
    logic [SQ_W-1:0]   sq_cnt_reg, sq_cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic              stall_inc, flush_inc;

    logic          mem_wait;
    logic          load_use;
    hazard_state_t resume_state;

    assign mem_wait = EX_MEM_MemAccess && !dmem_ready;
    assign load_use = load_use_hazard(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2);
    // After a freeze or stall, pick the squash tail back up if one is pending.
    assign resume_state = (sq_cnt_reg != '0) ? SQUASH : RUN;

    // State, squash/wait counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            sq_cnt_reg   <= '0;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sq_cnt_reg   <= sq_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    // Prioritised hazard resolution: mem wait > branch > load-use > squash tail.
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Flush  = 1'b0;
        MEM_WB_Flush  = 1'b0;
        state_next    = state_reg;
        sq_cnt_next   = sq_cnt_reg;
        wait_cnt_next = '0;
        mem_err_next  = mem_err_reg;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (mem_wait) begin
            // Freeze everything up to EX_MEM; MEM_WB gets bubbles until the access completes.
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Flush  = 1'b1;
            state_next    = MEM_WAIT;
            wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);
            if ((MEM_TIMEOUT != 0) && (wait_cnt_next >= WAIT_W'(MEM_TIMEOUT))) begin
                mem_err_next = 1'b1;
            end
            stall_inc = 1'b1;
        end else if (EX_MEM_BranchTaken) begin
            // Redirect: kill the three younger instructions, PC loads the target.
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            sq_cnt_next  = SQ_W'(IMEM_LAT);
            state_next   = (IMEM_LAT > 0) ? SQUASH : RUN;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            state_next  = resume_state;
            stall_inc   = 1'b1;
        end else if ((state_reg == SQUASH) && (sq_cnt_reg != '0)) begin
            // Stale fetches still arriving from the old path.
            IF_ID_Flush = 1'b1;
            sq_cnt_next = sq_cnt_reg - SQ_W'(1);
            state_next  = (sq_cnt_reg == SQ_W'(1)) ? RUN : SQUASH;
        end else begin
            state_next = resume_state;
        end

        // Reset holds every stage closed and bubbled, independent of the clock.
        if (!reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            MEM_WB_Flush = 1'b1;
        end
    end

    assign mem_err = mem_err_reg;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`else
    logic unused_inc;
    assign unused_inc = stall_inc ^ flush_inc;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (IMEM_LAT=2, MEM_TIMEOUT=3, CNT_W=8).
// Counter expectations follow HAZARD_PERF_CNT_EN: real counts when defined, zero otherwise.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector: {PC_W, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_F, ID_EX_F, EX_MEM_F, MEM_WB_F}
    localparam logic [7:0] C_NORM = 8'b1111_0000;
    localparam logic [7:0] C_RST  = 8'b0000_1111;
    localparam logic [7:0] C_FRZ  = 8'b0000_0001;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_BR   = 8'b1111_1110;
    localparam logic [7:0] C_SQ   = 8'b1111_1000;

    logic       clk   = 1'b1;
    logic       reset = 1'b0;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic       IF_ID_uses_rs2, ID_EX_MemRead, EX_MEM_BranchTaken, EX_MEM_MemAccess, dmem_ready;
    logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, mem_err;
    logic [7:0] stall_cnt, flush_cnt;

    typedef struct {
        string      nm;
        logic [7:0] ctrl;
        logic       me;
        logic [7:0] sc;
        logic [7:0] fc;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .IMEM_LAT    (2),
        .MEM_TIMEOUT (3),
        .CNT_W       (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .IF_ID_rs1          (IF_ID_rs1),
        .IF_ID_rs2          (IF_ID_rs2),
        .IF_ID_uses_rs2     (IF_ID_uses_rs2),
        .ID_EX_rd           (ID_EX_rd),
        .ID_EX_MemRead      (ID_EX_MemRead),
        .EX_MEM_BranchTaken (EX_MEM_BranchTaken),
        .EX_MEM_MemAccess   (EX_MEM_MemAccess),
        .dmem_ready         (dmem_ready),
        .PC_Write           (PC_Write),
        .IF_ID_Write        (IF_ID_Write),
        .ID_EX_Write        (ID_EX_Write),
        .EX_MEM_Write       (EX_MEM_Write),
        .IF_ID_Flush        (IF_ID_Flush),
        .ID_EX_Flush        (ID_EX_Flush),
        .EX_MEM_Flush       (EX_MEM_Flush),
        .MEM_WB_Flush       (MEM_WB_Flush),
        .mem_err            (mem_err),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    function automatic logic [7:0] ec(input int v);
        return PERF ? 8'(v) : 8'd0;
    endfunction

    // Monitor: compares one expectation per sampled cycle (or per async sample event).
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            if (sb_q.size() != 0) begin
                exp_t       e;
                logic [7:0] got_ctrl;
                e = sb_q.pop_front();
                got_ctrl = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                            IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush};
                n_checks++;
                if (got_ctrl !== e.ctrl || mem_err !== e.me ||
                    stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, want ctrl=%b err=%b stall=%0d flush=%0d",
                             e.nm, got_ctrl, mem_err, stall_cnt, flush_cnt,
                             e.ctrl, e.me, e.sc, e.fc);
                end else begin
                    $display("ok   %s: ctrl=%b err=%b stall=%0d flush=%0d",
                             e.nm, got_ctrl, mem_err, stall_cnt, flush_cnt);
                end
            end
        end
    end

    task automatic idle();
        IF_ID_rs1          = 5'd1;
        IF_ID_rs2          = 5'd2;
        IF_ID_uses_rs2     = 1'b1;
        ID_EX_rd           = 5'd0;
        ID_EX_MemRead      = 1'b0;
        EX_MEM_BranchTaken = 1'b0;
        EX_MEM_MemAccess   = 1'b0;
        dmem_ready         = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic uses2);
        ID_EX_MemRead  = 1'b1;
        ID_EX_rd       = rd;
        IF_ID_rs1      = rs1;
        IF_ID_rs2      = rs2;
        IF_ID_uses_rs2 = uses2;
    endtask

    // Push this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [7:0] ctrl, input logic me,
                       input int sc, input int fc);
        exp_t e;
        e.nm = nm; e.ctrl = ctrl; e.me = me; e.sc = ec(sc); e.fc = ec(fc);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1;
        cyc("rst_hold", C_RST, 1'b0, 0, 0);
        reset = 1'b1;
        cyc("after_rst", C_NORM, 1'b0, 0, 0);

        // Load-use on rs1 (ld x5; add x6,x5,x1), then bubble in execute.
        set_lu(5'd5, 5'd5, 5'd1, 1'b1);
        cyc("lu_rs1", C_LU, 1'b0, 0, 0);
        idle();
        cyc("lu_rs1_done", C_NORM, 1'b0, 1, 0);
        set_lu(5'd7, 5'd1, 5'd7, 1'b1);
        cyc("lu_rs2", C_LU, 1'b0, 1, 0);
        idle();
        cyc("lu_rs2_done", C_NORM, 1'b0, 2, 0);
        set_lu(5'd7, 5'd1, 5'd7, 1'b0);
        cyc("lu_rs2_unused", C_NORM, 1'b0, 2, 0);
        set_lu(5'd0, 5'd0, 5'd0, 1'b1);
        cyc("lu_x0", C_NORM, 1'b0, 2, 0);
        idle();

        // Taken branch: 1 cycle full flush + 2 squash cycles.
        EX_MEM_BranchTaken = 1'b1;
        cyc("br", C_BR, 1'b0, 2, 0);
        idle();
        cyc("sq1", C_SQ, 1'b0, 2, 1);
        cyc("sq2", C_SQ, 1'b0, 2, 1);
        cyc("sq_end", C_NORM, 1'b0, 2, 1);

        // Load-use coinciding with a taken branch: branch only.
        set_lu(5'd5, 5'd5, 5'd1, 1'b1);
        EX_MEM_BranchTaken = 1'b1;
        cyc("lu_br", C_BR, 1'b0, 2, 1);
        idle();
        cyc("lu_br_sq1", C_SQ, 1'b0, 2, 2);
        cyc("lu_br_sq2", C_SQ, 1'b0, 2, 2);
        cyc("lu_br_end", C_NORM, 1'b0, 2, 2);

        // Store waits 4 cycles; timeout 3 raises mem_err on the 3rd wait edge.
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        cyc("wait1", C_FRZ, 1'b0, 2, 2);
        cyc("wait2", C_FRZ, 1'b0, 3, 2);
        cyc("wait3", C_FRZ, 1'b0, 4, 2);
        cyc("wait4", C_FRZ, 1'b1, 5, 2);
        dmem_ready = 1'b1;
        cyc("wait_ready", C_NORM, 1'b1, 6, 2);
        idle();
        cyc("wait_after", C_NORM, 1'b1, 6, 2);

        // Branch, then a wait with a load-use pending; squash resumes afterwards.
        EX_MEM_BranchTaken = 1'b1;
        cyc("br2", C_BR, 1'b1, 6, 2);
        idle();
        set_lu(5'd5, 5'd5, 5'd1, 1'b1);
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        cyc("wait_lu", C_FRZ, 1'b1, 6, 3);
        dmem_ready = 1'b1;
        cyc("lu_after_wait", C_LU, 1'b1, 7, 3);
        idle();
        cyc("resume_sq1", C_SQ, 1'b1, 8, 3);
        cyc("resume_sq2", C_SQ, 1'b1, 8, 3);
        cyc("resume_end", C_NORM, 1'b1, 8, 3);

        // Asynchronous reset in the middle of a memory wait.
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        cyc("pre_rst_wait", C_FRZ, 1'b1, 8, 3);
        #1 reset = 1'b0;
        #1 begin
            exp_t e;
            e.nm = "async_rst"; e.ctrl = C_RST; e.me = 1'b0; e.sc = 8'd0; e.fc = 8'd0;
            sb_q.push_back(e);
            ->sample_ev;
        end
        @(posedge clk);
        #1;
        cyc("rst_in_wait", C_RST, 1'b0, 0, 0);
        idle();
        reset = 1'b1;
        cyc("rst_release", C_NORM, 1'b0, 0, 0);

        // Long wait: stall counter saturates at 255.
        EX_MEM_MemAccess = 1'b1;
        dmem_ready       = 1'b0;
        for (int i = 0; i < 258; i++) begin
            cyc("sat_wait", C_FRZ, (i >= 3), (i > 255) ? 255 : i, 0);
        end
        dmem_ready = 1'b1;
        cyc("sat_ready", C_NORM, 1'b1, 255, 0);
        idle();
        cyc("sat_after", C_NORM, 1'b1, 255, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
